// File: rtl/iic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iic_pkg
//  Brief    : Shared types and constants for the I2C EEPROM target.
//  Revision : 1.0
// ============================================================================
package iic_pkg;

    localparam logic [6:0] EEPROM_DEV_ADDR = 7'b1010000;
    localparam int         EEPROM_DEPTH    = 256;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DEVADDR = 4'd1,
        ST_DEVACK  = 4'd2,
        ST_WADDR   = 4'd3,
        ST_WDATA   = 4'd4,
        ST_WACK    = 4'd5,
        ST_RDATA   = 4'd6,
        ST_RACK    = 4'd7,
        ST_IGNORE  = 4'd8
    } iic_state_t;

endpackage
`default_nettype wire

// File: rtl/iic_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : iic_line_sync
//  Brief    : SCL/SDA synchronizers with registered rise/fall/START/STOP pulses.
//  Revision : 1.0
// ============================================================================
module iic_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;
    logic r_scl_rise, r_scl_fall, r_start, r_stop;

    // Lines reset to the idle-high bus level so reset itself creates no events
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
            r_scl_rise <= r_scl_sync & ~r_scl_prev;
            r_scl_fall <= ~r_scl_sync & r_scl_prev;
            r_start    <= r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
            r_stop     <= r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
        end
    end

    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_sda      = r_sda_prev;

endmodule
`default_nettype wire

// File: rtl/iic_eeprom_slave.sv
`default_nettype none
// ============================================================================
//  Module   : iic_eeprom_slave
//  Brief    : I2C target emulating a 256 x 8 serial EEPROM, open-drain SDA.
//  Revision : 1.0
// ============================================================================
module iic_eeprom_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = EEPROM_DEV_ADDR,
    parameter int         HOLD_CYC = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    iic_state_t    r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_ptr;
    logic          r_rw;
    logic          r_ack_clk;
    logic          r_pend_low;
    logic          r_sda_low;
    logic [HW-1:0] r_hold_cnt;
    logic [7:0]    r_mem [EEPROM_DEPTH];

    logic       w_rise, w_fall, w_start, w_stop, w_sda_in;
    logic [7:0] w_rx_byte;
    logic [7:0] w_mem_rd;
    logic       w_mem_we;

    iic_line_sync u_line_sync (
        .clk        (sysclk),
        .rst        (rst),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda_in)
    );

    assign sda       = r_sda_low ? 1'b0 : 1'bz;
    assign w_rx_byte = {r_shift[6:0], w_sda_in};
    assign w_mem_rd  = r_mem[r_ptr];
    assign w_mem_we  = !rst && !w_start && !w_stop && w_rise &&
                       (r_state == ST_WDATA) && (r_bit_cnt == 4'd7);

    always_ff @(posedge sysclk) begin
        if (w_mem_we)
            r_mem[r_ptr] <= w_rx_byte;
    end

    // Every SDA change is queued on an SCL fall and applied HOLD_CYC cycles
    // after that fall pulse (load HOLD_CYC-1, apply when the count reads 1).
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_ptr      <= 8'h00;
            r_rw       <= 1'b0;
            r_ack_clk  <= 1'b0;
            r_pend_low <= 1'b0;
            r_sda_low  <= 1'b0;
            r_hold_cnt <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
                if (r_hold_cnt == HW'(1))
                    r_sda_low <= r_pend_low;
            end
            if (w_start) begin
                r_state    <= ST_DEVADDR;
                r_bit_cnt  <= 4'd0;
                r_sda_low  <= 1'b0;
                r_hold_cnt <= '0;
            end else if (w_stop) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= 4'd0;
                r_sda_low  <= 1'b0;
                r_hold_cnt <= '0;
                busy       <= 1'b0;
            end else if (w_rise) begin
                case (r_state)
                    ST_DEVADDR, ST_WADDR, ST_WDATA: begin
                        r_shift   <= w_rx_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt <= 4'd0;
                            r_ack_clk <= 1'b0;
                            if (r_state == ST_DEVADDR) begin
                                if (r_shift[6:0] == DEV_ADDR) begin
                                    r_state <= ST_DEVACK;
                                    r_rw    <= w_sda_in;
                                    busy    <= 1'b1;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end else if (r_state == ST_WADDR) begin
                                r_ptr   <= w_rx_byte;
                                r_state <= ST_WACK;
                            end else begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= r_ptr;
                                wr_data   <= w_rx_byte;
                                r_ptr     <= r_ptr + 8'd1;
                                r_state   <= ST_WACK;
                            end
                        end
                    end
                    ST_DEVACK, ST_WACK: r_ack_clk <= 1'b1;
                    ST_RDATA: begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    ST_RACK: begin
                        if (w_sda_in)
                            r_state <= ST_IGNORE;
                        else
                            r_ack_clk <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_fall) begin
                case (r_state)
                    ST_DEVACK, ST_WACK, ST_RACK: begin
                        if (!r_ack_clk) begin
                            if (r_state != ST_RACK) begin
                                r_pend_low <= 1'b1;
                                r_hold_cnt <= HW'(HOLD_CYC - 1);
                            end
                        end else if (r_state == ST_WACK || (r_state == ST_DEVACK && !r_rw)) begin
                            r_state    <= (r_state == ST_WACK) ? ST_WDATA : ST_WADDR;
                            r_pend_low <= 1'b0;
                            r_hold_cnt <= HW'(HOLD_CYC - 1);
                        end else begin
                            r_state    <= ST_RDATA;
                            r_shift    <= w_mem_rd;
                            r_ptr      <= r_ptr + 8'd1;
                            r_bit_cnt  <= 4'd0;
                            r_pend_low <= ~w_mem_rd[7];
                            r_hold_cnt <= HW'(HOLD_CYC - 1);
                        end
                    end
                    ST_RDATA: begin
                        if (r_bit_cnt == 4'd8) begin
                            r_state    <= ST_RACK;
                            r_ack_clk  <= 1'b0;
                            r_bit_cnt  <= 4'd0;
                            r_pend_low <= 1'b0;
                        end else begin
                            r_pend_low <= ~r_shift[7];
                        end
                        r_hold_cnt <= HW'(HOLD_CYC - 1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iic_eeprom_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_iic_eeprom_slave
//  Brief    : Bit-banged I2C master against a transaction-level EEPROM model.
//  Revision : 1.0
// ============================================================================
module tb_iic_eeprom_slave;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic       m_scl  = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;
    logic       wr_strobe;
    logic [7:0] wr_addr, wr_data;
    logic       busy;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    iic_eeprom_slave #(.DEV_ADDR(7'b1010000), .HOLD_CYC(4)) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .scl       (m_scl),
        .sda       (sda),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl_mem   [256];
    bit          mdl_valid [256];
    logic [7:0]  mdl_ptr;
    logic [15:0] exp_wr [$];
    logic [15:0] got_wr [$];

    typedef struct {
        logic [7:0] dev_byte;
        bit         exp_ack;
    } addr_vec_t;
    addr_vec_t vecs [8];

    always @(negedge sysclk)
        if (wr_strobe === 1'b1) got_wr.push_back({wr_addr, wr_data});

    initial begin
        #1_200_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic i2c_start();
        wait_cyc(8); m_sda_low = 1'b0;
        wait_cyc(4); m_scl = 1'b1;
        wait_cyc(12); m_sda_low = 1'b1;
        wait_cyc(12); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_cyc(8); m_sda_low = 1'b1;
        wait_cyc(4); m_scl = 1'b1;
        wait_cyc(12); m_sda_low = 1'b0;
        wait_cyc(12);
    endtask

    task automatic write_bit(input logic b);
        wait_cyc(8); m_sda_low = ~b;
        wait_cyc(4); m_scl = 1'b1;
        wait_cyc(12); m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic v);
        wait_cyc(8); m_sda_low = 1'b0;
        wait_cyc(4); v = sda; m_scl = 1'b1;
        wait_cyc(12); m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        logic v;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(v);
        ack = (v == 1'b0);
    endtask

    task automatic read_byte(output logic [7:0] b, input bit master_ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(~master_ack);
    endtask

    task automatic check_writes(input string name);
        chk({name, "_wr_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk({name, "_wr_rec"}, got_wr[i], exp_wr[i]);
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic tx_write(input string name, input logic [7:0] addr,
                            input logic [31:0] dpack, input int n);
        bit ack;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hA0, ack); chk({name, "_dev_ack"}, ack, 1);
        chk({name, "_busy"}, busy, 1);
        write_byte(addr, ack); chk({name, "_addr_ack"}, ack, 1);
        mdl_ptr = addr;
        for (int i = 0; i < n; i++) begin
            d = dpack[31 - 8*i -: 8];
            write_byte(d, ack); chk({name, "_data_ack"}, ack, 1);
            mdl_mem[mdl_ptr]   = d;
            mdl_valid[mdl_ptr] = 1'b1;
            exp_wr.push_back({mdl_ptr, d});
            mdl_ptr = mdl_ptr + 8'd1;
        end
        i2c_stop();
        chk({name, "_busy_idle"}, busy, 0);
        check_writes(name);
    endtask

    task automatic tx_read(input string name, input bit random_addr,
                           input logic [7:0] addr, input int n);
        bit ack;
        logic [7:0] b;
        i2c_start();
        if (random_addr) begin
            write_byte(8'hA0, ack); chk({name, "_dev_ack"}, ack, 1);
            write_byte(addr, ack);  chk({name, "_addr_ack"}, ack, 1);
            mdl_ptr = addr;
            i2c_start();
        end
        write_byte(8'hA1, ack); chk({name, "_rd_ack"}, ack, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i < n - 1);
            if (mdl_valid[mdl_ptr]) chk({name, "_data"}, b, mdl_mem[mdl_ptr]);
            mdl_ptr = mdl_ptr + 8'd1;
        end
        i2c_stop();
        chk({name, "_busy_idle"}, busy, 0);
        check_writes(name);
    endtask

    initial begin
        bit          ack;
        logic [7:0]  b;
        logic [7:0]  dev_rd;
        int          kind, n;

        vecs[0] = '{8'hA2, 1'b0};
        vecs[1] = '{8'hA0, 1'b1};
        vecs[2] = '{8'hA1, 1'b1};
        vecs[3] = '{8'hA4, 1'b0};
        vecs[4] = '{8'h20, 1'b0};
        vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'hA1, 1'b1};
        vecs[7] = '{8'hE1, 1'b0};
        for (int i = 0; i < 256; i++) mdl_valid[i] = 1'b0;
        mdl_ptr = 8'h00;

        // Reset state
        wait_cyc(5);
        chk("rst_sda", sda, 1);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(20);

        // Byte write, random read, page writes with wrap, current-address read
        tx_write("bytewr", 8'h00, 32'hF5000000, 1);
        tx_read("rndrd", 1'b1, 8'h00, 1);
        tx_write("pre01", 8'h01, 32'h5AC30000, 2);
        tx_write("pagewr", 8'hFE, 32'h11223300, 3);
        tx_read("seqrd", 1'b1, 8'hFE, 3);
        tx_read("currd", 1'b0, 8'h00, 2);

        // Device-address table
        for (int v = 0; v < 8; v++) begin
            i2c_start();
            write_byte(vecs[v].dev_byte, ack);
            chk($sformatf("vec%0d_ack", v), ack, vecs[v].exp_ack);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_ack);
            if (!vecs[v].exp_ack) begin
                write_byte(8'h00, ack);
                chk($sformatf("vec%0d_ignore", v), ack, 0);
            end else if (!vecs[v].dev_byte[0]) begin
                write_byte(8'h01, ack);
                chk($sformatf("vec%0d_addr_ack", v), ack, 1);
                mdl_ptr = 8'h01;
            end else begin
                read_byte(b, 1'b0);
                if (mdl_valid[mdl_ptr]) chk($sformatf("vec%0d_data", v), b, mdl_mem[mdl_ptr]);
                mdl_ptr = mdl_ptr + 8'd1;
            end
            i2c_stop();
            chk($sformatf("vec%0d_busy_idle", v), busy, 0);
            check_writes($sformatf("vec%0d", v));
        end

        // STOP after 5 bits of a data byte
        tx_write("pre10", 8'h10, 32'h77000000, 1);
        i2c_start();
        write_byte(8'hA0, ack); chk("abort_dev_ack", ack, 1);
        write_byte(8'h10, ack); chk("abort_addr_ack", ack, 1);
        mdl_ptr = 8'h10;
        for (int i = 0; i < 5; i++) write_bit(1'b0);
        i2c_stop();
        check_writes("abort");
        tx_read("abort_rd", 1'b1, 8'h10, 1);

        // Reset while a read bit is driven low; also checks ACK timing
        tx_write("pre20", 8'h20, 32'h3C000000, 1);
        i2c_start();
        write_byte(8'hA0, ack); chk("rrst_dev_ack", ack, 1);
        write_byte(8'h20, ack); chk("rrst_addr_ack", ack, 1);
        i2c_start();
        dev_rd = 8'hA1;
        for (int i = 7; i >= 0; i--) write_bit(dev_rd[i]);
        wait_cyc(6); chk("ack_not_early", sda, 1);
        wait_cyc(1); chk("ack_on_time", sda, 0);
        wait_cyc(5); m_scl = 1'b1;
        wait_cyc(12); m_scl = 1'b0;
        wait_cyc(10); chk("rdata_bit7_low", sda, 0);
        chk("rdata_busy", busy, 1);
        rst = 1'b1;
        wait_cyc(1); chk("rrst_sda_released", sda, 1);
        chk("rrst_busy", busy, 0);
        wait_cyc(2);
        rst = 1'b0;
        mdl_ptr = 8'h00;
        i2c_stop();
        tx_read("rrst_currd", 1'b0, 8'h00, 1);
        tx_read("rrst_rndrd", 1'b1, 8'h20, 1);

        // Randomized transactions around the wrap point
        for (int t = 0; t < 25; t++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            b    = 8'hF8 + 8'($urandom_range(0, 15));
            case (kind)
                0: tx_write("rand_wr", b, $urandom, n);
                1: tx_read("rand_rnd", 1'b1, b, n);
                default: tx_read("rand_cur", 1'b0, 8'h00, n);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
